// File: rtl/forwarding_pkg.sv
// rtl/forwarding_pkg.sv - bypass select codes, FSM encodings and pipeline tag type
package forwarding_pkg;

  localparam int REG_AW = 5;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] FWD_REG = 3'b000;
  localparam logic [SEL_W-1:0] FWD_EXE = 3'b001;
  localparam logic [SEL_W-1:0] FWD_MEM = 3'b010;
  localparam logic [SEL_W-1:0] FWD_WB  = 3'b011;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_MEM_WAIT   = 2'b10
  } fsm_state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } tag_t;

  localparam int TAG_WIDTH = $bits(tag_t);

  // Tag valid already implies rd != 0, so x0 never produces a match.
  function automatic logic [SEL_W-1:0] fwd_select(
    input logic              used,
    input logic [REG_AW-1:0] idx,
    input tag_t              ex,
    input tag_t              mem,
    input tag_t              wb,
    input logic              wb_en
  );
    fwd_select = FWD_REG;
    if (used) begin
      if (ex.valid && ex.rd == idx)                fwd_select = FWD_EXE;
      else if (mem.valid && mem.rd == idx)         fwd_select = FWD_MEM;
      else if (wb_en && wb.valid && wb.rd == idx)  fwd_select = FWD_WB;
    end
  endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// rtl/hazard_tag_stage.sv - one pipeline destination tag register with hold and kill
module hazard_tag_stage
  import forwarding_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hold_i,
  input  logic kill_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  logic [TAG_WIDTH-1:0] tag_q;
  tag_t                 tag_d;

  always_comb begin
    tag_d = tag_t'(tag_q);
    if (!hold_i) begin
      tag_d = tag_i;
      if (kill_i) tag_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tag_q <= '0;
    else       tag_q <= tag_d;
  end

  assign tag_o = tag_t'(tag_q);

endmodule

// File: rtl/forwarding_hazard_controller.sv
// rtl/forwarding_hazard_controller.sv - operand bypass selects plus load-use / memory-wait stall sequencing
module forwarding_hazard_controller
  import forwarding_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_AW,
  parameter int FWD_SEL_WIDTH  = SEL_W,
  parameter bit ENABLE_WB_FWD  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      decode_valid,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rs2,
  input  logic                      decode_reads_rs1,
  input  logic                      decode_reads_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rd,
  input  logic                      decode_writes_rd,
  input  logic                      decode_is_load,
  input  logic                      mem_ready,
  input  logic                      flush,
  output logic [FWD_SEL_WIDTH-1:0]  rs1_forward_control,
  output logic [FWD_SEL_WIDTH-1:0]  rs2_forward_control,
  output logic                      stall_fetch,
  output logic                      stall_decode,
  output logic                      bubble_execute,
  output logic                      freeze_pipeline
);

  tag_t       dec_tag, ex_tag, mem_tag, wb_tag;
  fsm_state_e state_q, state_d;
  logic       flush_pend_q;
  logic       rs1_used, rs2_used, load_use, mem_wait, flush_eff, tag_kill;

  always_comb begin
    dec_tag.valid   = decode_valid & decode_writes_rd & (decode_rd != '0);
    dec_tag.rd      = decode_rd;
    dec_tag.is_load = decode_is_load;
  end

  assign rs1_used = decode_valid & decode_reads_rs1 & (decode_rs1 != '0);
  assign rs2_used = decode_valid & decode_reads_rs2 & (decode_rs2 != '0);

  assign rs1_forward_control = fwd_select(rs1_used, decode_rs1, ex_tag, mem_tag, wb_tag, ENABLE_WB_FWD);
  assign rs2_forward_control = fwd_select(rs2_used, decode_rs2, ex_tag, mem_tag, wb_tag, ENABLE_WB_FWD);

  // The EX slot is always bubbled while in LOAD_STALL, so the check is skipped there.
  assign load_use = (state_q != ST_LOAD_STALL) & ex_tag.valid & ex_tag.is_load &
                    ((rs1_used & (decode_rs1 == ex_tag.rd)) | (rs2_used & (decode_rs2 == ex_tag.rd)));
  assign mem_wait = mem_tag.valid & mem_tag.is_load & ~mem_ready;

  // A flush seen while frozen is remembered and takes effect on the release cycle.
  assign flush_eff = flush | (flush_pend_q & (state_q == ST_MEM_WAIT));

  always_comb begin
    stall_fetch     = 1'b0;
    stall_decode    = 1'b0;
    bubble_execute  = 1'b0;
    freeze_pipeline = 1'b0;
    state_d         = ST_RUN;
    if (mem_wait) begin
      freeze_pipeline = 1'b1;
      stall_fetch     = 1'b1;
      stall_decode    = 1'b1;
      state_d         = ST_MEM_WAIT;
    end else if (flush_eff) begin
      state_d = ST_RUN;
    end else if (load_use) begin
      stall_fetch    = 1'b1;
      stall_decode   = 1'b1;
      bubble_execute = 1'b1;
      state_d        = ST_LOAD_STALL;
    end
  end

  assign tag_kill = bubble_execute | flush_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= mem_wait & flush_eff;
    end
  end

  hazard_tag_stage u_ex_tag (
    .clk(clk), .reset(reset), .hold_i(mem_wait), .kill_i(tag_kill), .tag_i(dec_tag), .tag_o(ex_tag)
  );

  hazard_tag_stage u_mem_tag (
    .clk(clk), .reset(reset), .hold_i(mem_wait), .kill_i(1'b0), .tag_i(ex_tag), .tag_o(mem_tag)
  );

  hazard_tag_stage u_wb_tag (
    .clk(clk), .reset(reset), .hold_i(mem_wait), .kill_i(1'b0), .tag_i(mem_tag), .tag_o(wb_tag)
  );

endmodule
